// File: rtl/alu_muldiv_seq_if.sv
// Handshake and operand/result bundle for the sequential multiply/divide unit.
// The master drives requests; the slave (the unit itself) returns status and results.
interface alu_muldiv_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dz;

   modport master (output start, op, a, b, input busy, done, hi, lo, dz);
   modport slave  (input start, op, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/alu_muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide (signed and unsigned), one iteration per cycle.
// Define MULDIV_EARLY_EXIT_EN to skip the iteration phase for zero operands / zero divisor.
module alu_muldiv_seq (
   input  logic              clk,
   input  logic              reset,
   alu_muldiv_seq_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, stateNext;
   logic [1:0]  opReg;
   logic [31:0] operand;
   logic [31:0] rawA;
   logic [63:0] acc;
   logic [4:0]  count;
   logic        negMain;
   logic        negRem;
   logic        divZero;
   logic [31:0] hiReg, loReg;
   logic        dzReg;

   logic        aNeg, bNeg;
   logic [31:0] aMag, bMag;
   logic        skipCalc;
   logic        isDiv;
   logic [32:0] addA, addB, sum;
   logic        noBorrow;
   logic [63:0] accNext;
   logic [63:0] prod;
   logic [31:0] quo, rem;
   logic [31:0] fixHi, fixLo;

   assign isDiv = opReg[1];

   // Operand conditioning at accept: op[0]=0 selects the signed variants.
   assign aNeg = ~bus.op[0] & bus.a[31];
   assign bNeg = ~bus.op[0] & bus.b[31];
   assign aMag = aNeg ? (~bus.a + 32'd1) : bus.a;
   assign bMag = bNeg ? (~bus.b + 32'd1) : bus.b;

`ifdef MULDIV_EARLY_EXIT_EN
   assign skipCalc = bus.op[1] ? (bus.b == 32'd0) : ((bus.a == 32'd0) || (bus.b == 32'd0));
`else
   assign skipCalc = 1'b0;
`endif

   // The one shared adder: add for shift-add multiply, subtract for restoring divide.
   always_comb begin
      addA     = isDiv ? {1'b0, acc[62:31]} : {1'b0, acc[63:32]};
      addB     = isDiv ? ~{1'b0, operand} : (acc[0] ? {1'b0, operand} : 33'd0);
      sum      = addA + addB + {32'd0, isDiv};
      noBorrow = acc[63] | ~sum[32];
      if (isDiv)
         accNext = {(noBorrow ? sum[31:0] : acc[62:31]), acc[30:0], noBorrow};
      else
         accNext = {sum, acc[31:1]};
   end

   // Sign correction and divide-by-zero override applied when loading the results.
   always_comb begin
      prod  = (!isDiv && negMain) ? (~acc + 64'd1) : acc;
      quo   = negMain ? (~acc[31:0] + 32'd1) : acc[31:0];
      rem   = negRem ? (~acc[63:32] + 32'd1) : acc[63:32];
      fixHi = prod[63:32];
      fixLo = prod[31:0];
      if (divZero) begin
         fixHi = rawA;
         fixLo = 32'hFFFF_FFFF;
      end else if (isDiv) begin
         fixHi = rem;
         fixLo = quo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (bus.start) stateNext = skipCalc ? FIX : CALC;
         CALC: if (count == 5'd31) stateNext = FIX;
         FIX:  stateNext = DONE;
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Datapath registers; results change only in FIX so they survive until the next operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         opReg   <= 2'd0;
         operand <= 32'd0;
         rawA    <= 32'd0;
         acc     <= 64'd0;
         count   <= 5'd0;
         negMain <= 1'b0;
         negRem  <= 1'b0;
         divZero <= 1'b0;
         hiReg   <= 32'd0;
         loReg   <= 32'd0;
         dzReg   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               opReg   <= bus.op;
               rawA    <= bus.a;
               operand <= bus.op[1] ? bMag : aMag;
               acc     <= skipCalc ? 64'd0 : {32'd0, (bus.op[1] ? aMag : bMag)};
               count   <= 5'd0;
               negMain <= aNeg ^ bNeg;
               negRem  <= aNeg;
               divZero <= bus.op[1] && (bus.b == 32'd0);
            end
            CALC: begin
               acc   <= accNext;
               count <= count + 5'd1;
            end
            FIX: begin
               hiReg <= fixHi;
               loReg <= fixLo;
               dzReg <= divZero;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;
   assign bus.dz   = dzReg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: stimulus pushes reference results, a monitor pops on done.
module tb_alu_muldiv_seq;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          acceptCycle;
      int          latency;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cycleCnt = 0;
   int   lastAccept = 0;
   int   testsRun = 0;
   int   testsFailed = 0;
   exp_t expQ[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   alu_muldiv_seq_if ifc();

   alu_muldiv_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference results straight from integer arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t            e;
      longint          sp;
      longint unsigned up;
      int              q, r;
      e.dz = 1'b0;
      e.hi = 32'd0;
      e.lo = 32'd0;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {e.hi, e.lo} = sp;
         end
         2'b01: begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            {e.hi, e.lo} = up;
         end
         default: begin
            if (b == 32'd0) begin
               e.dz = 1'b1;
               e.hi = a;
               e.lo = 32'hFFFF_FFFF;
            end else if (op == 2'b11) begin
               e.lo = a / b;
               e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000;
               e.hi = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               e.lo = q;
               e.hi = r;
            end
         end
      endcase
      e.latency = 34;
`ifdef MULDIV_EARLY_EXIT_EN
      if (op[1] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) e.latency = 2;
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && ifc.done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("hi", {32'd0, ifc.hi}, {32'd0, e.hi});
            checkOutput("lo", {32'd0, ifc.lo}, {32'd0, e.lo});
            checkOutput("dz", {63'd0, ifc.dz}, {63'd0, e.dz});
            checkOutput("latency", 64'(cycleCnt - e.acceptCycle), 64'(e.latency));
            checkOutput("busy with done", {63'd0, ifc.busy}, 64'd1);
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op    = op;
      ifc.a     = a;
      ifc.b     = b;
      e = model(op, a, b);
      e.acceptCycle = cycleCnt;
      lastAccept = cycleCnt;
      expQ.push_back(e);
   endtask

   // Waits for done; optionally pulses start with fresh operands at given cycles after accept.
   task automatic waitDone(input int p1, input int p2);
      bit seen = 0;
      int k;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ifc.op = 2'($urandom_range(0, 3));
         ifc.a  = $urandom;
         ifc.b  = $urandom;
         if (ifc.done === 1'b1) begin
            ifc.start = 1'b1;
            seen = 1;
            break;
         end
         k = cycleCnt - lastAccept;
         ifc.start = (k == p1 || k == p2);
      end
      if (!seen) begin
         checkOutput("done timeout", 64'd0, 64'd1);
         expQ.delete();
         ifc.start = 1'b0;
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      ifc.start = 1'b0;
      ifc.op    = 2'd0;
      ifc.a     = 32'd0;
      ifc.b     = 32'd0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", {63'd0, ifc.busy}, 64'd0);
      checkOutput("reset done", {63'd0, ifc.done}, 64'd0);
      checkOutput("reset hi", {32'd0, ifc.hi}, 64'd0);
      checkOutput("reset lo", {32'd0, ifc.lo}, 64'd0);
      checkOutput("reset dz", {63'd0, ifc.dz}, 64'd0);
      reset = 1'b0;

      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitDone(0, 0);
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);         waitDone(0, 0);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);         waitDone(0, 0);
      applyStimulus(2'b11, 32'd100, 32'd0);               waitDone(0, 0);
      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); waitDone(0, 0);
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0);         waitDone(0, 0);
      applyStimulus(2'b00, 32'd0, 32'h1234_5678);         waitDone(0, 0);
      applyStimulus(2'b01, 32'h1234_5678, 32'h9ABC_DEF0); waitDone(5, 20);

      // Abort a MULTU with reset ten cycles in, then reuse the unit.
      applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ifc.start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      checkOutput("abort busy", {63'd0, ifc.busy}, 64'd0);
      checkOutput("abort done", {63'd0, ifc.done}, 64'd0);
      checkOutput("abort hi", {32'd0, ifc.hi}, 64'd0);
      checkOutput("abort lo", {32'd0, ifc.lo}, 64'd0);
      repeat (40) @(negedge clk);
      applyStimulus(2'b11, 32'd10, 32'd3); waitDone(0, 0);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand());
         waitDone($urandom_range(1, 33), $urandom_range(1, 33));
      end

      @(negedge clk);
      ifc.start = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
